// File: rtl/video_timing_sink.sv
// rtl/video_timing_sink.sv - HDMI raster timing generator and pixel sink for the scaled-video stream
module video_timing_sink #(
  parameter int unsigned H_ACTIVE   = 1920,
  parameter int unsigned H_FP       = 88,
  parameter int unsigned H_SYNC     = 44,
  parameter int unsigned H_BP       = 148,
  parameter int unsigned V_ACTIVE   = 1080,
  parameter int unsigned V_FP       = 4,
  parameter int unsigned V_SYNC     = 5,
  parameter int unsigned V_BP       = 36,
  parameter logic        HS_POL     = 1'b1,
  parameter logic        VS_POL     = 1'b1,
  parameter int unsigned FSYNC_LEN  = 16,
  parameter logic [23:0] FILL_COLOR = 24'h000000
) (
  input  logic        vout_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] in_dat,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        frame_sync_n,
  output logic        hdmi_hs,
  output logic        hdmi_vs,
  output logic        hdmi_de,
  output logic [23:0] hdmi_rgb,
  output logic [15:0] underflow_cnt,
  output logic [15:0] frame_cnt,
  output logic        in_sync
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

  // PRIME waits out the partial frame after enable; SKIP rides out a frame that underflowed.
  typedef enum logic [1:0] {IDLE, PRIME, RUN, SKIP} state_t;

  state_t      state_q, state_d;
  logic [11:0] h_q, h_d, v_q, v_d;
  logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_n_q, fs_n_d;
  logic [23:0] rgb_q, rgb_d;
  logic [15:0] underflow_cnt_q, underflow_cnt_d, frame_cnt_q, frame_cnt_d;

  logic        active, hs_raw, vs_raw, wrap, fs_win, accept, underflow;
  logic [31:0] fs_pos;

  // Decode the current raster position; the frame-sync window is measured
  // linearly from the first blanking line so it may span several lines.
  always_comb begin
    active = (h_q < H_ACT) && (v_q < V_ACT);
    hs_raw = (h_q >= HS_START) && (h_q < HS_END);
    vs_raw = (v_q >= VS_START) && (v_q < VS_END);
    wrap   = (h_q == H_LAST) && (v_q == V_LAST);
    fs_pos = (32'(v_q) - V_ACTIVE) * H_TOTAL + 32'(h_q);
    fs_win = (v_q >= V_ACT) && (fs_pos < FSYNC_LEN);
  end

  assign in_ready  = (state_q == RUN) && active;
  assign accept    = in_ready && in_valid;
  assign underflow = in_ready && !in_valid;
  assign in_sync   = (state_q == RUN);

  // Next state, raster counters and next values of every registered output.
  always_comb begin
    state_d         = state_q;
    h_d             = h_q;
    v_d             = v_q;
    de_d            = 1'b0;
    hs_d            = ~HS_POL;
    vs_d            = ~VS_POL;
    fs_n_d          = 1'b0;
    rgb_d           = 24'h0;
    underflow_cnt_d = 16'h0;
    frame_cnt_d     = 16'h0;

    if (!enable) begin
      state_d = IDLE;
      h_d     = 12'h0;
      v_d     = V_ACT;
    end else begin
      if (h_q == H_LAST) begin
        h_d = 12'h0;
        v_d = (v_q == V_LAST) ? 12'h0 : v_q + 12'd1;
      end else begin
        h_d = h_q + 12'd1;
      end
      case (state_q)
        IDLE:    state_d = PRIME;
        PRIME:   if (wrap) state_d = RUN;
        RUN:     if (underflow) state_d = SKIP;
        SKIP:    if (wrap) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end

    // IDLE drives the reset values, so outputs settle one cycle after entry.
    if (state_q != IDLE) begin
      de_d   = active;
      hs_d   = hs_raw ? HS_POL : ~HS_POL;
      vs_d   = vs_raw ? VS_POL : ~VS_POL;
      fs_n_d = !fs_win;
      if (accept) begin
        rgb_d = in_dat;
      end else if (active) begin
        rgb_d = FILL_COLOR;
      end
      underflow_cnt_d = underflow_cnt_q;
      if (underflow && (underflow_cnt_q != 16'hFFFF)) begin
        underflow_cnt_d = underflow_cnt_q + 16'd1;
      end
      frame_cnt_d = wrap ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end
  end

  // State, counter and output registers; rst overrides enable.
  always_ff @(posedge vout_clk) begin
    if (rst) begin
      state_q         <= IDLE;
      h_q             <= 12'h0;
      v_q             <= V_ACT;
      de_q            <= 1'b0;
      hs_q            <= ~HS_POL;
      vs_q            <= ~VS_POL;
      fs_n_q          <= 1'b0;
      rgb_q           <= 24'h0;
      underflow_cnt_q <= 16'h0;
      frame_cnt_q     <= 16'h0;
    end else begin
      state_q         <= state_d;
      h_q             <= h_d;
      v_q             <= v_d;
      de_q            <= de_d;
      hs_q            <= hs_d;
      vs_q            <= vs_d;
      fs_n_q          <= fs_n_d;
      rgb_q           <= rgb_d;
      underflow_cnt_q <= underflow_cnt_d;
      frame_cnt_q     <= frame_cnt_d;
    end
  end

  assign hdmi_de       = de_q;
  assign hdmi_hs       = hs_q;
  assign hdmi_vs       = vs_q;
  assign frame_sync_n  = fs_n_q;
  assign hdmi_rgb      = rgb_q;
  assign underflow_cnt = underflow_cnt_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_sink.sv
// tb/tb_video_timing_sink.sv - directed bench with a frame-level reference model for video_timing_sink
module tb_video_timing_sink;

  localparam int          HA    = 8;
  localparam int          HT    = 14;
  localparam int          VA    = 4;
  localparam int          VT    = 7;
  localparam int          FL    = 4;
  localparam int          FRAME = HT * VT;
  localparam int          SOF   = VA * HT;
  localparam logic [23:0] FILL  = 24'hFF00FF;

  logic        vout_clk;
  logic        rst, enable, in_valid;
  logic [23:0] in_dat;
  logic        in_ready, frame_sync_n, hdmi_hs, hdmi_vs, hdmi_de, in_sync;
  logic [23:0] hdmi_rgb;
  logic [15:0] underflow_cnt, frame_cnt;

  video_timing_sink #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .FSYNC_LEN(4), .FILL_COLOR(24'hFF00FF)
  ) dut (
    .vout_clk(vout_clk), .rst(rst), .enable(enable),
    .in_dat(in_dat), .in_valid(in_valid), .in_ready(in_ready),
    .frame_sync_n(frame_sync_n), .hdmi_hs(hdmi_hs), .hdmi_vs(hdmi_vs),
    .hdmi_de(hdmi_de), .hdmi_rgb(hdmi_rgb),
    .underflow_cnt(underflow_cnt), .frame_cnt(frame_cnt), .in_sync(in_sync)
  );

  initial begin
    vout_clk = 1'b0;
    forever #5 vout_clk = ~vout_clk;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: a linear raster position plus "raster live" and
  // "this frame is being consumed" flags, advanced once per clock edge.
  bit          m_live, m_consume, model_go;
  int          m_pos, src_next;
  logic [15:0] m_uf, m_fc;
  logic        e_de, e_hs, e_vs, e_fs_n;
  logic [23:0] e_rgb;
  logic [15:0] e_uf, e_fc;

  function automatic bit pos_active(input int p);
    return ((p % HT) < HA) && ((p / HT) < VA);
  endfunction

  task automatic model_quiet();
    e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_fs_n = 1'b0; e_rgb = 24'h0;
    m_uf = 16'h0; m_fc = 16'h0; e_uf = 16'h0; e_fc = 16'h0;
  endtask

  task automatic model_step();
    int  line, px;
    bit  act, take;
    if (rst) begin
      model_quiet();
      m_live = 1'b0; m_consume = 1'b0; m_pos = SOF;
      return;
    end
    if (!m_live) begin
      model_quiet();
      if (enable) begin
        m_live = 1'b1; m_consume = 1'b0; m_pos = SOF + 1;
      end
      return;
    end
    line   = m_pos / HT;
    px     = m_pos % HT;
    act    = pos_active(m_pos);
    take   = m_consume && act && in_valid;
    e_de   = act;
    e_hs   = (px >= 10) && (px < 12);
    e_vs   = (line == 5);
    e_fs_n = !((m_pos >= SOF) && (m_pos < SOF + FL));
    e_rgb  = take ? in_dat : (act ? FILL : 24'h0);
    if (take) src_next++;
    if (m_consume && act && !in_valid) begin
      if (m_uf != 16'hFFFF) m_uf = m_uf + 16'd1;
      m_consume = 1'b0;
    end
    if (m_pos == FRAME - 1) begin
      m_fc = m_fc + 16'd1;
      m_consume = 1'b1;
    end
    if (!enable) begin
      m_live = 1'b0; m_consume = 1'b0; m_pos = SOF;
    end else begin
      m_pos = (m_pos + 1) % FRAME;
    end
    e_uf = m_uf;
    e_fc = m_fc;
  endtask

  initial begin
    m_live = 1'b0; m_consume = 1'b0; m_pos = SOF; src_next = 1; model_go = 1'b0;
    model_quiet();
    forever begin
      @(posedge vout_clk);
      model_step();
      model_go = 1'b1;
    end
  end

  // Every cycle, every output against the model.
  initial begin
    forever begin
      @(negedge vout_clk);
      if (model_go) begin
        chk("hdmi_de", hdmi_de, e_de);
        chk("hdmi_hs", hdmi_hs, e_hs);
        chk("hdmi_vs", hdmi_vs, e_vs);
        chk("frame_sync_n", frame_sync_n, e_fs_n);
        chk("hdmi_rgb", hdmi_rgb, e_rgb);
        chk("underflow_cnt", underflow_cnt, e_uf);
        chk("frame_cnt", frame_cnt, e_fc);
        chk("in_ready", in_ready, m_live && m_consume && pos_active(m_pos));
        chk("in_sync", in_sync, m_live && m_consume);
      end
    end
  end

  int          cyc, de_n, hs_n, vs_n, fs_lo;
  logic [15:0] last_fc;
  logic [23:0] pix_q[$];
  int          fc_at[$];

  task automatic clear_tallies();
    de_n = 0; hs_n = 0; vs_n = 0; fs_lo = 0;
    pix_q.delete();
  endtask

  task automatic cycle();
    @(posedge vout_clk);
    @(negedge vout_clk);
    cyc++;
    if (hdmi_de) begin
      de_n++;
      pix_q.push_back(hdmi_rgb);
    end
    if (hdmi_hs) hs_n++;
    if (hdmi_vs) vs_n++;
    if (!frame_sync_n) fs_lo++;
    if (frame_cnt != last_fc) begin
      fc_at.push_back(cyc);
      last_fc = frame_cnt;
    end
    in_dat = 24'(src_next);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (n < 300) begin
      cycle();
      n++;
      if (in_ready === 1'b1) break;
    end
  endtask

  task automatic run_until(input int pos, input string name);
    int guard;
    guard = 0;
    while ((m_pos != pos) && (guard < 200)) begin
      cycle();
      guard++;
    end
    if (guard >= 200) chk({name, "_timeout"}, guard, 0);
  endtask

  initial begin
    int n;
    cyc = 0; last_fc = 16'h0;
    clear_tallies();
    rst = 1'b1; enable = 1'b1; in_valid = 1'b1; in_dat = 24'd1;

    repeat (3) cycle();
    chk("rst_de", hdmi_de, 0);
    chk("rst_rgb", hdmi_rgb, 0);
    chk("rst_hs", hdmi_hs, 0);
    chk("rst_vs", hdmi_vs, 0);
    chk("rst_fsync_n", frame_sync_n, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_in_sync", in_sync, 0);
    chk("rst_counts", {underflow_cnt, frame_cnt}, 0);

    rst = 1'b0;
    wait_ready(n);
    chk("ready_after_reset", n, 42);

    clear_tallies();
    repeat (FRAME) cycle();
    chk("frame1_de_cycles", de_n, 32);
    chk("frame1_hs_cycles", hs_n, 14);
    chk("frame1_vs_cycles", vs_n, 14);
    chk("frame1_fsync_low", fs_lo, 4);
    chk("frame1_pixels", pix_q.size(), 32);
    for (int i = 0; i < 32 && i < pix_q.size(); i++) chk("frame1_rgb", pix_q[i], i + 1);
    chk("frame1_uf", underflow_cnt, 0);
    chk("frame_cnt_2", frame_cnt, 2);
    if (fc_at.size() >= 2) chk("frame_period", fc_at[fc_at.size() - 1] - fc_at[fc_at.size() - 2], 98);
    else chk("frame_period_seen", fc_at.size(), 2);

    run_until(19, "to_underflow");
    in_valid = 1'b0;
    cycle();
    in_valid = 1'b1;
    chk("uf_pixel_fill", hdmi_rgb, 24'hFF00FF);
    chk("uf_count_1", underflow_cnt, 1);
    chk("uf_in_ready", in_ready, 0);
    chk("uf_in_sync", in_sync, 0);
    run_until(0, "to_frame3");
    chk("resync_in_sync", in_sync, 1);
    clear_tallies();
    repeat (FRAME) cycle();
    chk("frame3_pixels", pix_q.size(), 32);
    if (pix_q.size() == 32) begin
      chk("frame3_first_rgb", pix_q[0], 46);
      chk("frame3_last_rgb", pix_q[31], 77);
    end

    run_until(31, "to_disable");
    enable = 1'b0;
    cycle();
    chk("dis_in_ready", in_ready, 0);
    cycle();
    chk("dis_de", hdmi_de, 0);
    chk("dis_fsync_n", frame_sync_n, 0);
    repeat (5) cycle();
    enable = 1'b1;
    wait_ready(n);
    chk("ready_after_enable", n, 42);

    @(posedge vout_clk);
    #2;
    force dut.underflow_cnt_q = 16'hFFFE;
    m_uf = 16'hFFFE;
    e_uf = 16'hFFFE;
    #1;
    release dut.underflow_cnt_q;
    @(negedge vout_clk);
    in_dat = 24'(src_next);
    in_valid = 1'b0;
    cycle();
    in_valid = 1'b1;
    chk("uf_saturate_1", underflow_cnt, 16'hFFFF);
    run_until(0, "to_next_frame");
    in_valid = 1'b0;
    cycle();
    in_valid = 1'b1;
    chk("uf_saturate_2", underflow_cnt, 16'hFFFF);
    repeat (20) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
